// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: DEPTH-byte FIFO feeding an LSB-first 8N1 serializer.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
module uart_tx_buf #(
  parameter int unsigned CLK_DIV = 868,
  parameter int unsigned DEPTH   = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_i,
  input  logic [7:0]               wdata_i,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     busy_o,
  output logic                     ovf_o,
  output logic                     tx_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    data_q, data_d;
  logic          tx_q, tx_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q;
  logic          full_q, full_d, empty_q, empty_d;
  logic          ovf_q;
  logic          push, pop, bit_end;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    head;

  assign head = mem_q[rd_ptr_q[AW-1:0]];

  // Pops only ever look at the registered empty flag, so a byte written at
  // edge E is popped no earlier than E+1, and the pop never frees space early.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    push    = wr_i & ~full_q;
    bit_end = (cnt_q == BIT_LAST);
    if (state_q != IDLE) cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (!empty_q) begin
          pop     = 1'b1;
          data_d  = head;
          tx_d    = 1'b0;
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          idx_d   = '0;
          tx_d    = data_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = ^data_q;
            state_d = PARITY;
`else
            tx_d    = 1'b1;
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = data_q[idx_d];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (!empty_q) begin
            pop     = 1'b1;
            data_d  = head;
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    empty_d  = (wr_ptr_d == rd_ptr_d);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= wr_ptr_d - rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= wr_i & full_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  assign full_o  = full_q;
  assign level_o = level_q;
  assign busy_o  = (state_q != IDLE);
  assign ovf_o   = ovf_q;
  assign tx_o    = tx_q;
endmodule
